// File: rtl/mem_arbiter.sv
// mem_arbiter: two-requester req/gnt memory arbiter with in-order response routing via an owner FIFO.
// Rev 1.0 -- define MEM_ARBITER_RR_EN for round-robin tie-break (default build: DATA over INSTR).
`default_nettype none

module mem_arbiter #(
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,

  input  logic        instr_req_i,
  input  logic [31:0] instr_addr_i,
  output logic        instr_gnt_o,
  output logic        instr_rvalid_o,
  output logic [31:0] instr_rdata_o,

  input  logic        data_req_i,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_wdata_i,
  output logic        data_gnt_o,
  output logic        data_rvalid_o,
  output logic [31:0] data_rdata_o,

  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [3:0]  bus_be_o,
  output logic [31:0] bus_addr_o,
  output logic [31:0] bus_wdata_o,
  input  logic        bus_gnt_i,
  input  logic        bus_rvalid_i,
  input  logic [31:0] bus_rdata_i,

  output logic        err_o
);

  localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

  typedef enum logic {OWNER_INSTR = 1'b0, OWNER_DATA = 1'b1} owner_t;
  typedef enum logic {ST_ARB = 1'b0, ST_HOLD = 1'b1} state_t;

  state_t           state;
  owner_t           locked_owner;
  owner_t           sel;
  owner_t           owner_mem [MAX_OUTSTANDING];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             any_req;
  logic             sel_req;
  logic             pop;
  logic             push;
  logic             fifo_full;
  logic             hold_drop;
`ifdef MEM_ARBITER_RR_EN
  owner_t           last_grant;
`endif

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(MAX_OUTSTANDING - 1)) return '0;
    return p + PTR_W'(1);
  endfunction

  assign any_req = instr_req_i | data_req_i;
  assign pop     = bus_rvalid_i & (count != '0);
  // A response retiring this cycle frees a slot for a same-cycle grant.
  assign fifo_full = (count == CNT_W'(MAX_OUTSTANDING)) & ~pop;

  always_comb begin
    sel = OWNER_INSTR;
    if (state == ST_HOLD) begin
      sel = locked_owner;
    end else if (instr_req_i && data_req_i) begin
`ifdef MEM_ARBITER_RR_EN
      if (last_grant == OWNER_INSTR) sel = OWNER_DATA;
      else                           sel = OWNER_INSTR;
`else
      sel = OWNER_DATA;
`endif
    end else if (data_req_i) begin
      sel = OWNER_DATA;
    end
  end

  assign sel_req   = (sel == OWNER_DATA) ? data_req_i : instr_req_i;
  // The locked owner withdrew its request: never grant on its behalf.
  assign hold_drop = (state == ST_HOLD) & ~sel_req;
  assign bus_req_o = any_req & ~fifo_full & ~hold_drop;
  assign push      = bus_req_o & bus_gnt_i;

  assign instr_gnt_o = push & (sel == OWNER_INSTR);
  assign data_gnt_o  = push & (sel == OWNER_DATA);

  assign bus_addr_o  = (sel == OWNER_DATA) ? data_addr_i  : instr_addr_i;
  assign bus_we_o    = (sel == OWNER_DATA) ? data_we_i    : 1'b0;
  assign bus_be_o    = (sel == OWNER_DATA) ? data_be_i    : 4'hF;
  assign bus_wdata_o = (sel == OWNER_DATA) ? data_wdata_i : 32'h0;

  assign instr_rvalid_o = pop & (owner_mem[rd_ptr] == OWNER_INSTR);
  assign data_rvalid_o  = pop & (owner_mem[rd_ptr] == OWNER_DATA);
  assign instr_rdata_o  = bus_rdata_i;
  assign data_rdata_o   = bus_rdata_i;

  always_ff @(posedge clk_i) begin
    if (push) owner_mem[wr_ptr] <= sel;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state        <= ST_ARB;
      locked_owner <= OWNER_INSTR;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      err_o        <= 1'b0;
`ifdef MEM_ARBITER_RR_EN
      last_grant   <= OWNER_INSTR;
`endif
    end else begin
      err_o <= (bus_rvalid_i & (count == '0)) | hold_drop;

      case (state)
        ST_ARB: begin
          if (bus_req_o && !bus_gnt_i) begin
            state        <= ST_HOLD;
            locked_owner <= sel;
          end
        end
        ST_HOLD: begin
          if (hold_drop || bus_gnt_i) state <= ST_ARB;
        end
        default: state <= ST_ARB;
      endcase

      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      count <= count + CNT_W'(push) - CNT_W'(pop);
`ifdef MEM_ARBITER_RR_EN
      if (push) last_grant <= sel;
`endif
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenarios plus randomized traffic checked against a queue-based reference model.
`default_nettype none

module tb_mem_arbiter;

  localparam int MAXO = 2;
`ifdef MEM_ARBITER_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ireq, dreq, dwe, gnt, rvalid;
  logic [31:0] iaddr, daddr, dwdata, rdata;
  logic [3:0]  dbe;

  logic        instr_gnt, instr_rvalid, data_gnt, data_rvalid;
  logic [31:0] instr_rdata, data_rdata;
  logic        bus_req, bus_we, err;
  logic [3:0]  bus_be;
  logic [31:0] bus_addr, bus_wdata;

  always #5 clk = ~clk;

  mem_arbiter #(.MAX_OUTSTANDING(MAXO)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .instr_req_i(ireq), .instr_addr_i(iaddr), .instr_gnt_o(instr_gnt),
    .instr_rvalid_o(instr_rvalid), .instr_rdata_o(instr_rdata),
    .data_req_i(dreq), .data_we_i(dwe), .data_be_i(dbe), .data_addr_i(daddr),
    .data_wdata_i(dwdata), .data_gnt_o(data_gnt), .data_rvalid_o(data_rvalid),
    .data_rdata_o(data_rdata),
    .bus_req_o(bus_req), .bus_we_o(bus_we), .bus_be_o(bus_be), .bus_addr_o(bus_addr),
    .bus_wdata_o(bus_wdata), .bus_gnt_i(gnt), .bus_rvalid_i(rvalid), .bus_rdata_i(rdata),
    .err_o(err)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: outstanding owners in order (0 = INSTR, 1 = DATA).
  bit q[$];
  bit hold_v, hold_o, last_g, err_prev;

  logic obs_igrant, obs_dgrant, obs_irv, obs_drv, obs_breq, obs_err, obs_we;
  logic [31:0] obs_addr, obs_irdata;
  logic [3:0]  obs_be;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic idle();
    ireq = 0; dreq = 0; dwe = 0; dbe = 4'h0; iaddr = 0; daddr = 0; dwdata = 0;
    gnt = 0; rvalid = 0; rdata = 0;
  endtask

  // Inputs are already driven (just after a falling edge); check, advance model, move to next falling edge.
  task automatic step();
    bit pop, full, own, drop, breq, acc;
    #2;
    obs_igrant = instr_gnt; obs_dgrant = data_gnt; obs_irv = instr_rvalid; obs_drv = data_rvalid;
    obs_breq = bus_req; obs_err = err; obs_addr = bus_addr; obs_be = bus_be; obs_we = bus_we;
    obs_irdata = instr_rdata;

    pop  = rvalid && (q.size() > 0);
    full = (int'(q.size()) - int'(pop)) == MAXO;
    if (hold_v)            own = hold_o;
    else if (ireq && dreq) own = RR ? !last_g : 1'b1;
    else                   own = dreq;
    drop = hold_v && !(own ? dreq : ireq);
    breq = (ireq || dreq) && !full && !drop;
    acc  = breq && gnt;

    check("bus_req", 32'(bus_req), 32'(breq));
    check("instr_gnt", 32'(instr_gnt), 32'(acc && !own));
    check("data_gnt", 32'(data_gnt), 32'(acc && own));
    if (breq) begin
      check("bus_addr", bus_addr, own ? daddr : iaddr);
      check("bus_we", 32'(bus_we), 32'(own ? dwe : 1'b0));
      check("bus_be", 32'(bus_be), 32'(own ? dbe : 4'hF));
      check("bus_wdata", bus_wdata, own ? dwdata : 32'h0);
    end
    check("instr_rvalid", 32'(instr_rvalid), 32'(pop && q[0] == 1'b0));
    check("data_rvalid", 32'(data_rvalid), 32'(pop && q[0] == 1'b1));
    if (pop) begin
      check("instr_rdata", instr_rdata, rdata);
      check("data_rdata", data_rdata, rdata);
    end
    check("err", 32'(err), 32'(err_prev));

    if (!rst_n) begin
      q.delete(); hold_v = 0; last_g = 0; err_prev = 0;
    end else begin
      err_prev = (rvalid && q.size() == 0) || drop;
      if (pop) void'(q.pop_front());
      if (acc) begin q.push_back(own); last_g = own; end
      if (!hold_v && breq && !gnt) begin hold_v = 1; hold_o = own; end
      else if (hold_v && (gnt || drop)) hold_v = 0;
    end
    @(negedge clk);
  endtask

  task automatic grant_instr(input logic [31:0] a);
    idle(); ireq = 1; iaddr = a; gnt = 1; step();
  endtask

  initial begin
    hold_v = 0; hold_o = 0; last_g = 0; err_prev = 0;
    idle(); rst_n = 0;
    @(negedge clk);
    step(); step();
    rst_n = 1;
    idle(); step();
    check("reset_bus_req", 32'(obs_breq), 0);
    check("reset_err", 32'(obs_err), 0);

    // Single fetch, response two cycles after grant.
    grant_instr(32'h100);
    check("fetch_gnt", 32'(obs_igrant), 1);
    check("fetch_addr", obs_addr, 32'h100);
    idle(); step();
    idle(); rvalid = 1; rdata = 32'hDEADBEEF; step();
    check("fetch_rvalid", 32'(obs_irv), 1);
    check("fetch_rdata", obs_irdata, 32'hDEADBEEF);
    check("fetch_no_drv", 32'(obs_drv), 0);
    idle(); step();

    // Tie-break sequence over four back-to-back grants.
    for (int k = 0; k < 4; k++) begin
      idle(); ireq = 1; dreq = 1; iaddr = 32'h1000 + k; daddr = 32'h2000 + k;
      gnt = 1; rvalid = (k > 0); rdata = 32'hA0 + k;
      step();
      check($sformatf("tie_grant%0d", k), 32'(obs_dgrant),
            32'(RR ? ((k % 2) == 0) : 1'b1));
    end
    idle(); rvalid = 1; step();
    idle(); step();

    // Store held on the bus while the slave stalls; instr arrives mid-stall.
    for (int k = 0; k < 3; k++) begin
      idle(); dreq = 1; dwe = 1; dbe = 4'h3; daddr = 32'h200; dwdata = 32'h55AA;
      ireq = (k > 0); iaddr = 32'h300;
      step();
      check($sformatf("stall_addr%0d", k), obs_addr, 32'h200);
      check($sformatf("stall_be%0d", k), 32'(obs_be), 32'h3);
      check($sformatf("stall_we%0d", k), 32'(obs_we), 1);
      check($sformatf("stall_ign%0d", k), 32'(obs_igrant), 0);
    end
    gnt = 1; step();
    check("stall_dgnt", 32'(obs_dgrant), 1);
    idle(); rvalid = 1; step();
    idle(); step();

    // FIFO full back-pressure, then simultaneous pop and push.
    grant_instr(32'h400);
    grant_instr(32'h404);
    grant_instr(32'h408);
    check("full_no_req", 32'(obs_breq), 0);
    idle(); ireq = 1; iaddr = 32'h40C; gnt = 1; rvalid = 1; rdata = 32'h1; step();
    check("full_pop", 32'(obs_irv), 1);
    check("full_push", 32'(obs_igrant), 1);
    idle(); ireq = 1; iaddr = 32'h410; gnt = 1; step();
    check("full_still", 32'(obs_breq), 0);
    idle(); rvalid = 1; step();
    idle(); rvalid = 1; step();
    idle(); step();

    // Response with nothing outstanding.
    idle(); rvalid = 1; rdata = 32'hBAD; step();
    check("orphan_irv", 32'(obs_irv), 0);
    check("orphan_drv", 32'(obs_drv), 0);
    idle(); step();
    check("orphan_err", 32'(obs_err), 1);
    idle(); step();
    check("orphan_err_clr", 32'(obs_err), 0);

    // Locked owner withdraws its request while stalled.
    idle(); dreq = 1; daddr = 32'h500; step();
    idle(); ireq = 1; iaddr = 32'h600; gnt = 1; step();
    check("drop_no_gnt", 32'(obs_igrant), 0);
    idle(); step();
    check("drop_err", 32'(obs_err), 1);

    // Reset with two outstanding discards them.
    grant_instr(32'h700);
    grant_instr(32'h704);
    idle(); rst_n = 0; step();
    rst_n = 1;
    idle(); rvalid = 1; step();
    check("rst_discard_irv", 32'(obs_irv), 0);
    idle(); step();
    check("rst_discard_err", 32'(obs_err), 1);

    // Randomized traffic; requests stay up until granted, with rare withdrawals.
    idle();
    for (int c = 0; c < 3000; c++) begin
      if (!ireq || obs_igrant) begin
        ireq = ($urandom_range(0, 99) < 60); iaddr = $urandom;
      end else if ($urandom_range(0, 99) < 2) ireq = 0;
      if (!dreq || obs_dgrant) begin
        dreq = ($urandom_range(0, 99) < 60); daddr = $urandom; dwdata = $urandom;
        dwe = $urandom_range(0, 1); dbe = 4'($urandom);
      end else if ($urandom_range(0, 99) < 2) dreq = 0;
      gnt    = ($urandom_range(0, 99) < 50);
      rvalid = ($urandom_range(0, 99) < 45);
      rdata  = $urandom;
      rst_n  = !($urandom_range(0, 999) < 5);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
